// File: rtl/mult_share_arbiter_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: FSM state
// encodings and a ceil-log2 helper used to size index and counter fields.
package mult_share_arbiter_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Ceil-log2, never less than 1 so it can always size a vector.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/mult_share_arbiter_core.sv
// Shift-add sequential multiplier datapath (seq_mult_core role).
// start loads the operands and clears the accumulator; each step cycle adds
// the shifted multiplicand when the current multiplier LSB is set.
// last flags the final step so the controller can leave RUN.
module mult_share_arbiter_core
    import mult_share_arbiter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 step,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   acc,
    output logic                 last
);

    localparam int CW = clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    // Operand load on start, one shift-add iteration per step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
        end else if (step) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
        end
    end

    assign last = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one shift-add multiplier between NUM_REQ
// requesters, with valid/ready handshakes on both sides.
// Optional build macro: MULT_ZERO_SKIP_EN -- when defined, an operation with
// a zero operand bypasses RUN and goes straight to DONE with a zero product.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | searching for a requester, grant is combinational
// RUN     | WIDTH shift-add iterations in the datapath
// DONE    | product presented, waiting for rsp_ready
module mult_share_arbiter
    import mult_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 4,
    parameter int IDW     = clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [2*WIDTH-1:0]       rsp_p,
    output logic [IDW-1:0]           rsp_id,
    output logic                     busy
);

    state_t             state;
    state_t             state_nxt;
    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     id;
    logic [IDW-1:0]     winner;
    logic [IDW-1:0]     scan_idx;
    logic [IDW-1:0]     ptr_nxt;
    logic               found;
    logic               hs;
    logic               skip;
    logic               last;
    logic [WIDTH-1:0]   a_sel;
    logic [WIDTH-1:0]   b_sel;
    logic [2*WIDTH-1:0] acc;

    // Round-robin search: first valid requester at or after ptr, wrapping.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = IDW'((int'(ptr) + k) % NUM_REQ);
            if (!found && req_valid[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end
    end

    // One-hot grant, only while idle; held low during reset as well.
    always_comb begin
        req_ready = '0;
        if (!rst && state == ST_IDLE && found) begin
            req_ready[winner] = 1'b1;
        end
    end

    assign hs = |(req_valid & req_ready);

    // Operand mux driven by the current winner.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDW'(i) == winner) begin
                a_sel = req_a[i*WIDTH +: WIDTH];
                b_sel = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef MULT_ZERO_SKIP_EN
    assign skip = (a_sel == '0) || (b_sel == '0);
`else
    assign skip = 1'b0;
`endif

    assign ptr_nxt = (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + IDW'(1);

    // Next-state logic; DONE always returns to IDLE so no grant can be
    // issued in the same cycle as the response handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (hs)        state_nxt = skip ? ST_DONE : ST_RUN;
            ST_RUN:  if (last)      state_nxt = ST_DONE;
            ST_DONE: if (rsp_ready) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    // State, round-robin pointer and owner id registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            ptr   <= '0;
            id    <= '0;
        end else begin
            state <= state_nxt;
            if (hs) begin
                ptr <= ptr_nxt;
                id  <= winner;
            end
        end
    end

    mult_share_arbiter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .start (hs),
        .step  (state == ST_RUN),
        .a     (a_sel),
        .b     (b_sel),
        .acc   (acc),
        .last  (last)
    );

    assign rsp_valid = (state == ST_DONE);
    assign rsp_p     = acc;
    assign rsp_id    = id;
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter (NUM_REQ=2, WIDTH=4).
module tb_mult_share_arbiter;

    localparam int NUM_REQ = 2;
    localparam int WIDTH   = 4;
    localparam int IDW     = 1;

`ifdef MULT_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [2*WIDTH-1:0]       rsp_p;
    logic [IDW-1:0]           rsp_id;
    logic                     busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mult_share_arbiter #(
        .NUM_REQ (NUM_REQ),
        .WIDTH   (WIDTH),
        .IDW     (IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_p     (rsp_p),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    typedef struct {
        logic [1:0] valid;
        logic [3:0] a0;
        logic [3:0] b0;
        logic [3:0] a1;
        logic [3:0] b1;
        logic [1:0] exp_ready;
        logic       exp_id;
        logic [7:0] exp_p;
        bit         zero;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One complete transaction: grant check, latency, product, id, release.
    task automatic do_op(input vec_t v, input string tag);
        int lat;
        int exp_lat;
        bit busy_ok;
        @(negedge clk);
        req_valid = v.valid;
        req_a     = {v.a1, v.a0};
        req_b     = {v.b1, v.b0};
        #1;
        check($sformatf("%s ready", tag), 32'(req_ready), 32'(v.exp_ready));
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        req_a     = 8'hA5;
        req_b     = 8'h5A;
        lat       = 0;
        busy_ok   = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            if (busy !== 1'b1 || req_ready !== 2'b00) busy_ok = 1'b0;
            if (rsp_valid === 1'b1) begin
                lat = n;
                break;
            end
            @(negedge clk);
        end
        exp_lat = (SKIP && v.zero) ? 1 : WIDTH + 1;
        check($sformatf("%s latency", tag), 32'(lat), 32'(exp_lat));
        check($sformatf("%s busy", tag), 32'(busy_ok), 32'd1);
        check($sformatf("%s product", tag), 32'(rsp_p), 32'(v.exp_p));
        check($sformatf("%s id", tag), 32'(rsp_id), 32'(v.exp_id));
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check($sformatf("%s rsp_valid cleared", tag), 32'(rsp_valid), 32'd0);
        check($sformatf("%s idle", tag), 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit stable;
        bit no_rsp;

        // Sequence from reset (ptr = 0), grants worked out by hand.
        vecs[0] = '{2'b01, 4'd3,  4'd2,  4'd0,  4'd0,  2'b01, 1'b0, 8'd6,   1'b0};
        vecs[1] = '{2'b10, 4'd0,  4'd0,  4'd15, 4'd15, 2'b10, 1'b1, 8'd225, 1'b0};
        vecs[2] = '{2'b11, 4'd5,  4'd5,  4'd9,  4'd7,  2'b01, 1'b0, 8'd25,  1'b0};
        vecs[3] = '{2'b11, 4'd5,  4'd5,  4'd9,  4'd7,  2'b10, 1'b1, 8'd63,  1'b0};
        vecs[4] = '{2'b11, 4'd5,  4'd5,  4'd9,  4'd7,  2'b01, 1'b0, 8'd25,  1'b0};
        vecs[5] = '{2'b01, 4'd4,  4'd0,  4'd0,  4'd0,  2'b01, 1'b0, 8'd0,   1'b1};
        vecs[6] = '{2'b10, 4'd0,  4'd0,  4'd0,  4'd11, 2'b10, 1'b1, 8'd0,   1'b1};
        vecs[7] = '{2'b10, 4'd0,  4'd0,  4'd12, 4'd13, 2'b10, 1'b1, 8'd156, 1'b0};
        vecs[8] = '{2'b01, 4'd7,  4'd1,  4'd0,  4'd0,  2'b01, 1'b0, 8'd7,   1'b0};
        vecs[9] = '{2'b11, 4'd2,  4'd3,  4'd11, 4'd6,  2'b10, 1'b1, 8'd66,  1'b0};

        rst       = 1'b1;
        req_valid = 2'b11;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset req_ready", 32'(req_ready), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_p", 32'(rsp_p), 32'd0);
        check("reset rsp_id", 32'(rsp_id), 32'd0);
        rst       = 1'b0;
        req_valid = '0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i], $sformatf("vec%0d", i));
        end
        // ptr is now 0 after vec9 granted requester 1.

        // Back-pressure: response held for 10 cycles with both requesters waiting.
        @(negedge clk);
        req_valid = 2'b01;
        req_a     = {4'd0, 4'd6};
        req_b     = {4'd0, 4'd7};
        #1;
        check("bp grant", 32'(req_ready), 32'b01);
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b11;
        req_a     = 8'hFF;
        req_b     = 8'hFF;
        repeat (4) @(negedge clk);
        check("bp rsp_valid", 32'(rsp_valid), 32'd1);
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (rsp_valid !== 1'b1 || rsp_p !== 8'd42 || rsp_id !== 1'b0 || req_ready !== 2'b00)
                stable = 1'b0;
            @(negedge clk);
        end
        check("bp held stable", 32'(stable), 32'd1);
        rsp_ready = 1'b1;
        #1;
        check("bp no bypass grant", 32'(req_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("bp rsp cleared", 32'(rsp_valid), 32'd0);
        check("bp next grant", 32'(req_ready), 32'b10);
        req_valid = '0;
        @(negedge clk);

        // Reset asserted during the second RUN cycle.
        req_valid = 2'b01;
        req_a     = {4'd0, 4'd5};
        req_b     = {4'd0, 4'd3};
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        check("rst mid first run cycle busy", 32'(busy), SKIP ? 32'd1 : 32'd1);
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 2'b10;
        #1;
        check("rst mid busy", 32'(busy), 32'd0);
        check("rst mid rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst mid rsp_p", 32'(rsp_p), 32'd0);
        check("rst mid rsp_id", 32'(rsp_id), 32'd0);
        check("rst mid req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        req_valid = '0;
        no_rsp    = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0) no_rsp = 1'b0;
        end
        check("rst mid no response", 32'(no_rsp), 32'd1);

        // Recovery after reset; pointer back to 0 so requester 0 wins.
        do_op('{2'b11, 4'd3, 4'd3, 4'd2, 4'd8, 2'b01, 1'b0, 8'd9, 1'b0}, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
